// File: rtl/serial_mag_comparator.sv
// -----------------------------------------------------------------------------
// serial_mag_comparator
//
// Multi-cycle magnitude comparator for wide operands. Each clock resolves one
// DIGIT-bit slice, starting at the most significant slice. When EARLY_EXIT is
// set, the compare stops at the first slice that differs. Otherwise all
// slices are scanned, which gives a fixed latency.
//
// Signed compares are turned into unsigned compares by flipping the sign bit
// of both operands when they are captured (offset-binary). After that, every
// slice compare is a plain DIGIT-bit unsigned compare.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request a compare; accepted in IDLE or DONE
//   signed_mode  1 = two's-complement, 0 = unsigned (captured with start)
//   a, b         WIDTH-bit operands (captured with start)
//   busy         high while slices are being compared
//   done         one-cycle pulse; eq/alb/agb valid from this cycle on
//   eq, alb, agb result flags; held until the next accepted start
//
// State table
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start, last result (if any) held
//   ST_CMP  | comparing slice k_q, one slice per clock
//   ST_DONE | single cycle, done pulse, result valid
// -----------------------------------------------------------------------------
module serial_mag_comparator #(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             alb,
    output logic             agb
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam bit EE   = (EARLY_EXIT != 0);

    localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);
    localparam logic [KW-1:0]    K_TOP     = KW'(NDIG - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             fd_q, fd_d;
    logic             gt_q, gt_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic             eq_q, eq_d;
    logic             alb_q, alb_d;
    logic             agb_q, agb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] slice_a;
    logic [DIGIT-1:0] slice_b;
    logic             slice_ne;
    logic             slice_gt;
    logic             new_diff;
    logic             last_slice;
    logic             accept;
    logic             finish;
    logic             dec_fd;
    logic             dec_gt;

    // Slice select as an explicit mux over slice indices, so the datapath
    // never needs a WIDTH-wide shifter.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (k_q == KW'(i)) begin
                slice_a = ra_q[i*DIGIT +: DIGIT];
                slice_b = rb_q[i*DIGIT +: DIGIT];
            end
        end
    end

    assign slice_ne   = (slice_a != slice_b);
    assign slice_gt   = (slice_a > slice_b);
    assign new_diff   = slice_ne && !fd_q;
    assign last_slice = (k_q == '0);
    assign accept     = start && (state_q != ST_CMP);

    // The compare stops at the first difference (early exit) or after the
    // least significant slice.
    assign finish     = (state_q == ST_CMP) && ((new_diff && EE) || last_slice);

    // The decision combines the first difference already latched with a
    // difference found in the current slice.
    assign dec_fd     = fd_q || slice_ne;
    assign dec_gt     = new_diff ? slice_gt : gt_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        fd_d    = fd_q;
        gt_d    = gt_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        eq_d    = eq_q;
        alb_d   = alb_q;
        agb_d   = agb_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    ra_d    = a ^ (signed_mode ? SIGN_MASK : '0);
                    rb_d    = b ^ (signed_mode ? SIGN_MASK : '0);
                    eq_d    = 1'b0;
                    alb_d   = 1'b0;
                    agb_d   = 1'b0;
                    k_d     = K_TOP;
                    fd_d    = 1'b0;
                    gt_d    = 1'b0;
                    state_d = ST_CMP;
                end
            end

            ST_CMP: begin
                // A lower slice never overrides a difference found higher up.
                // The direction is kept internally, so the visible flags
                // stay 0 until the deciding edge.
                if (new_diff) begin
                    fd_d = 1'b1;
                    gt_d = slice_gt;
                end
                if (finish) begin
                    eq_d    = !dec_fd;
                    agb_d   = dec_fd && dec_gt;
                    alb_d   = dec_fd && !dec_gt;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d == ST_CMP);
    assign done_d = (state_d == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            fd_q    <= 1'b0;
            gt_q    <= 1'b0;
            ra_q    <= '0;
            rb_q    <= '0;
            eq_q    <= 1'b0;
            alb_q   <= 1'b0;
            agb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            fd_q    <= fd_d;
            gt_q    <= gt_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            eq_q    <= eq_d;
            alb_q   <= alb_d;
            agb_q   <= agb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign eq   = eq_q;
    assign alb  = alb_q;
    assign agb  = agb_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
module tb_serial_mag_comparator;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    // index 0: EARLY_EXIT=1, index 1: EARLY_EXIT=0
    logic busy_o [2];
    logic done_o [2];
    logic eq_o   [2];
    logic alb_o  [2];
    logic agb_o  [2];

    int total = 0;
    int bad   = 0;

    serial_mag_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(1)) u_ee1 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy_o[0]), .done(done_o[0]),
        .eq(eq_o[0]), .alb(alb_o[0]), .agb(agb_o[0])
    );

    serial_mag_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(0)) u_ee0 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy_o[1]), .done(done_o[1]),
        .eq(eq_o[1]), .alb(alb_o[1]), .agb(agb_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Result code: 0 = equal, 1 = a<b, 2 = a>b
    function automatic int ref_result(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                      input logic sm);
        if (sm) begin
            if ($signed(x) < $signed(y)) return 1;
            if ($signed(x) > $signed(y)) return 2;
            return 0;
        end
        if (x < y) return 1;
        if (x > y) return 2;
        return 0;
    endfunction

    // Number of slices evaluated with early exit: up to and including the
    // first differing slice from the top, otherwise all of them.
    function automatic int ref_slices(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        for (int i = NDIG - 1; i >= 0; i--)
            if (x[i*DIGIT +: DIGIT] != y[i*DIGIT +: DIGIT]) return NDIG - i;
        return NDIG;
    endfunction

    int m_rem  [2];
    int m_res  [2];
    bit m_done [2];
    bit m_eq   [2];
    bit m_alb  [2];
    bit m_agb  [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 2; j++) begin
                m_rem[j] = 0; m_res[j] = 0; m_done[j] = 0;
                m_eq[j] = 0; m_alb[j] = 0; m_agb[j] = 0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (m_rem[j] == 0 && start) begin
                    m_res[j]  = ref_result(a, b, signed_mode);
                    m_rem[j]  = (j == 0) ? ref_slices(a, b) : NDIG;
                    m_done[j] = 0;
                    m_eq[j] = 0; m_alb[j] = 0; m_agb[j] = 0;
                end else if (m_rem[j] > 0) begin
                    m_rem[j]--;
                    if (m_rem[j] == 0) begin
                        m_done[j] = 1;
                        m_eq[j]   = (m_res[j] == 0);
                        m_alb[j]  = (m_res[j] == 1);
                        m_agb[j]  = (m_res[j] == 2);
                    end
                end else begin
                    m_done[j] = 0;
                end
            end
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("busy[%0d]", j), int'(busy_o[j]), int'(m_rem[j] > 0));
            chk($sformatf("done[%0d]", j), int'(done_o[j]), int'(m_done[j]));
            chk($sformatf("eq[%0d]",   j), int'(eq_o[j]),   int'(m_eq[j]));
            chk($sformatf("alb[%0d]",  j), int'(alb_o[j]),  int'(m_alb[j]));
            chk($sformatf("agb[%0d]",  j), int'(agb_o[j]),  int'(m_agb[j]));
        end
    end

    // ---------------- directed vectors ----------------
    // Called at a negedge. Drives one start, then watches both instances for
    // their done pulse and checks latency and result against literals.
    // exp_res: 0 eq, 1 lt, 2 gt; exp_m: slices evaluated with early exit.
    task automatic run_vec(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                           input logic sm, input int exp_res, input int exp_m,
                           input bit hold);
        bit seen [2];
        logic [2:0] exp_flags;
        exp_flags = (exp_res == 0) ? 3'b100 : (exp_res == 1) ? 3'b010 : 3'b001;
        seen[0] = 0;
        seen[1] = 0;
        a = va; b = vb; signed_mode = sm; start = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (hold && c < 4) begin
                start = 1'b1; a = '0; b = '0;
            end else begin
                start = 1'b0;
            end
            if (c == 1) begin
                chk("busy_after_start", int'(busy_o[0] & busy_o[1]), 1);
                chk("flags_clear_while_busy",
                    int'({eq_o[0], alb_o[0], agb_o[0], eq_o[1], alb_o[1], agb_o[1]}), 0);
            end
            for (int j = 0; j < 2; j++) begin
                if (!seen[j] && done_o[j]) begin
                    seen[j] = 1;
                    chk($sformatf("latency[%0d] %h/%h", j, va, vb), c,
                        (j == 0) ? exp_m + 1 : NDIG + 1);
                    chk($sformatf("result[%0d] %h/%h", j, va, vb),
                        int'({eq_o[j], alb_o[j], agb_o[j]}), int'(exp_flags));
                end
            end
            if (seen[0] && seen[1]) break;
        end
        if (!(seen[0] && seen[1]))
            chk("done_timeout", 0, 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            int'({busy_o[0], done_o[0], eq_o[0], alb_o[0], agb_o[0],
                  busy_o[1], done_o[1], eq_o[1], alb_o[1], agb_o[1]}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_vec(16'h1234, 16'h1234, 1'b0, 0, 4, 1'b0);
        @(negedge clk);
        run_vec(16'h9000, 16'h1000, 1'b0, 2, 1, 1'b0);
        @(negedge clk);
        run_vec(16'h9000, 16'h1000, 1'b1, 1, 1, 1'b0);
        @(negedge clk);
        run_vec(16'h0005, 16'h0006, 1'b0, 1, 4, 1'b1);
        @(negedge clk);
        // back-to-back: second start lands in the EARLY_EXIT=0 done cycle
        run_vec(16'hF000, 16'h0FFF, 1'b0, 2, 1, 1'b0);
        run_vec(16'h0001, 16'h0001, 1'b0, 0, 4, 1'b0);
        @(negedge clk);
        run_vec(16'h0120, 16'h0130, 1'b1, 1, 3, 1'b0);
        @(negedge clk);

        // asynchronous reset in the middle of a compare
        a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("busy_before_reset", int'(busy_o[0] & busy_o[1]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            int'({busy_o[0], done_o[0], eq_o[0], alb_o[0], agb_o[0],
                  busy_o[1], done_o[1], eq_o[1], alb_o[1], agb_o[1]}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", int'({busy_o[0], done_o[0], busy_o[1], done_o[1]}), 0);

        run_vec(16'h8000, 16'h7FFF, 1'b1, 1, 1, 1'b0);
        @(negedge clk);
        run_vec(16'hFFFF, 16'hFFFE, 1'b1, 2, 4, 1'b0);
        @(negedge clk);
        run_vec(16'h7FFF, 16'h8000, 1'b0, 1, 1, 1'b0);

        // result must be held while idle
        repeat (3) @(negedge clk);
        chk("result_hold", int'({eq_o[0], alb_o[0], agb_o[0], eq_o[1], alb_o[1], agb_o[1]}),
            int'(6'b010_010));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
